// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: address width, broadcast constant and the
// RX address-filter state encoding.
package eth_pkg;

  localparam int          ETH_ADDR_BYTES = 6;
  localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    EMIT = 2'd1,
    PASS = 2'd2,
    DROP = 2'd3
  } filt_state_e;

endpackage

// File: rtl/eth_addr_match.sv
// Combinational destination-address compare: unicast to mac_addr, broadcast,
// or any group address when accept_mcast is set.
module eth_addr_match
  import eth_pkg::*;
(
  input  logic [8*ETH_ADDR_BYTES-1:0] hdr_addr,
  input  logic [8*ETH_ADDR_BYTES-1:0] mac_addr,
  input  logic                        accept_mcast,
  output logic                        match
);

  // The group bit is bit 0 of the first byte on the wire.
  logic group_addr;
  assign group_addr = hdr_addr[8*ETH_ADDR_BYTES-8];

  assign match = (hdr_addr == mac_addr) ||
                 (hdr_addr == ETH_BCAST_ADDR) ||
                 (accept_mcast && group_addr);

endmodule

// File: rtl/eth_rx_addr_filter.sv
// RX destination-address filter: buffers the DA, then forwards or silently drops
// the frame. Define ETH_RX_ADDR_FILTER_STATS_EN to add saturating stat counters.
// Streams use AXI-Stream valid/ready: a beat moves on a clock edge where valid
// and ready are both high; a raised valid holds its beat until that handshake.
module eth_rx_addr_filter
  import eth_pkg::*;
#(
  parameter int HDR_BYTES = ETH_ADDR_BYTES,
  parameter bit RUNT_DROP = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] mac_addr,
  input  logic        promisc,
  input  logic        accept_mcast,
  output logic        drop_pulse,
  output filt_state_e dbg_state
`ifdef ETH_RX_ADDR_FILTER_STATS_EN
  ,
  output logic [31:0] stat_accepted,
  output logic [31:0] stat_dropped,
  output logic [15:0] stat_runt
`endif
);

  localparam int            W        = $clog2(HDR_BYTES + 1);
  localparam logic [W-1:0]  LAST_IDX = W'(HDR_BYTES - 1);
  localparam logic [W-1:0]  HDR_CNT  = W'(HDR_BYTES);

  filt_state_e state_q, state_d;
  logic [W-1:0] idx_q, idx_d, cnt_q, cnt_d, eidx_q, eidx_d;
  logic [7:0]   hdr_data_q [HDR_BYTES];
  logic [7:0]   hdr_data_d [HDR_BYTES];
  logic         hdr_last_q [HDR_BYTES];
  logic         hdr_last_d [HDR_BYTES];
  logic         hdr_user_q [HDR_BYTES];
  logic         hdr_user_d [HDR_BYTES];
  logic         drop_pulse_q, drop_pulse_d;
  logic [8*ETH_ADDR_BYTES-1:0] cand_addr;
  logic         addr_match, accept;

  // The last DA byte is compared straight off the bus so the decision lands
  // in the same cycle that byte is accepted.
  always_comb begin
    cand_addr = '0;
    for (int i = 0; i < HDR_BYTES - 1; i++) begin
      cand_addr[8*(HDR_BYTES-1-i) +: 8] = hdr_data_q[i];
    end
    cand_addr[7:0] = s_axis_tdata;
  end

  eth_addr_match u_match (
    .hdr_addr     (cand_addr),
    .mac_addr     (mac_addr),
    .accept_mcast (accept_mcast),
    .match        (addr_match)
  );

  assign accept = promisc || addr_match;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= HDR;
      idx_q        <= '0;
      cnt_q        <= '0;
      eidx_q       <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      eidx_q       <= eidx_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  always_ff @(posedge clock) begin
    hdr_data_q <= hdr_data_d;
    hdr_last_q <= hdr_last_d;
    hdr_user_q <= hdr_user_d;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    eidx_d       = eidx_q;
    hdr_data_d   = hdr_data_q;
    hdr_last_d   = hdr_last_q;
    hdr_user_d   = hdr_user_q;
    drop_pulse_d = 1'b0;
    case (state_q)
      HDR: begin
        if (s_axis_tvalid) begin
          hdr_data_d[idx_q] = s_axis_tdata;
          hdr_last_d[idx_q] = s_axis_tlast;
          hdr_user_d[idx_q] = s_axis_tuser;
          eidx_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (accept) begin
              state_d = EMIT;
              cnt_d   = HDR_CNT;
            end else if (s_axis_tlast) begin
              drop_pulse_d = 1'b1;
            end else begin
              state_d = DROP;
            end
          end else if (s_axis_tlast) begin
            idx_d = '0;
            if (RUNT_DROP) begin
              drop_pulse_d = 1'b1;
            end else begin
              state_d = EMIT;
              cnt_d   = idx_q + W'(1);
            end
          end else begin
            idx_d = idx_q + W'(1);
          end
        end
      end
      EMIT: begin
        if (m_axis_tready) begin
          if (eidx_q == cnt_q - W'(1)) begin
            state_d = hdr_last_q[eidx_q] ? HDR : PASS;
          end else begin
            eidx_d = eidx_q + W'(1);
          end
        end
      end
      PASS: begin
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d = HDR;
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_pulse_d = 1'b1;
          state_d      = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    if (reset) begin
      case (state_q)
        HDR, DROP: s_axis_tready = 1'b1;
        EMIT: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = hdr_data_q[eidx_q];
          m_axis_tlast  = hdr_last_q[eidx_q];
          m_axis_tuser  = hdr_last_q[eidx_q] && hdr_user_q[eidx_q];
        end
        PASS: begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tlast  = s_axis_tlast;
          m_axis_tuser  = s_axis_tuser;
        end
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign dbg_state  = state_q;

`ifdef ETH_RX_ADDR_FILTER_STATS_EN
  logic        accept_evt, runt_evt;
  logic [31:0] stat_acc_q, stat_acc_d, stat_drop_q, stat_drop_d;
  logic [15:0] stat_runt_q, stat_runt_d;

  assign accept_evt = (state_q == HDR) && (state_d == EMIT);
  assign runt_evt   = (state_q == HDR) && s_axis_tvalid && s_axis_tlast &&
                      (idx_q != LAST_IDX);

  always_comb begin
    stat_acc_d  = (accept_evt && stat_acc_q != '1) ? stat_acc_q + 32'd1 : stat_acc_q;
    stat_drop_d = (drop_pulse_d && stat_drop_q != '1) ? stat_drop_q + 32'd1 : stat_drop_q;
    stat_runt_d = (runt_evt && stat_runt_q != '1) ? stat_runt_q + 16'd1 : stat_runt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_acc_q  <= '0;
      stat_drop_q <= '0;
      stat_runt_q <= '0;
    end else begin
      stat_acc_q  <= stat_acc_d;
      stat_drop_q <= stat_drop_d;
      stat_runt_q <= stat_runt_d;
    end
  end

  assign stat_accepted = stat_acc_q;
  assign stat_dropped  = stat_drop_q;
  assign stat_runt     = stat_runt_q;
`endif

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Directed bench for eth_rx_addr_filter: scoreboard of expected output beats,
// drop-pulse counts and reset behaviour, plus a RUNT_DROP=0 instance for runts.
module tb_eth_rx_addr_filter;
  import eth_pkg::*;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [47:0] mac;
  logic        promisc, accept_mcast, drop_pulse;
  filt_state_e dbg_state;

  logic        nr_tvalid, nr_tready;
  logic [7:0]  nr_m_tdata;
  logic        nr_m_tvalid, nr_m_tlast, nr_m_tuser, nr_drop;
  logic        nr_m_tready = 1'b1;
  filt_state_e nr_state;

`ifdef ETH_RX_ADDR_FILTER_STATS_EN
  logic [31:0] st_acc, st_drop, nr_st_acc, nr_st_drop;
  logic [15:0] st_runt, nr_st_runt;
`endif

  int n_vec = 0, n_err = 0;
  int drop_cnt = 0, vld_cnt = 0, stall_cnt = 0;
  bit bp_en = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] nr_q[$];

  always #20 clock = ~clock;

  eth_rx_addr_filter #(.HDR_BYTES(6), .RUNT_DROP(1'b1)) u_dut (
    .clock(clock), .reset(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .mac_addr(mac), .promisc(promisc), .accept_mcast(accept_mcast),
    .drop_pulse(drop_pulse), .dbg_state(dbg_state)
`ifdef ETH_RX_ADDR_FILTER_STATS_EN
    , .stat_accepted(st_acc), .stat_dropped(st_drop), .stat_runt(st_runt)
`endif
  );

  eth_rx_addr_filter #(.HDR_BYTES(6), .RUNT_DROP(1'b0)) u_dut_nr (
    .clock(clock), .reset(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(nr_tvalid), .s_axis_tready(nr_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(nr_m_tdata), .m_axis_tvalid(nr_m_tvalid), .m_axis_tready(nr_m_tready),
    .m_axis_tlast(nr_m_tlast), .m_axis_tuser(nr_m_tuser),
    .mac_addr(mac), .promisc(promisc), .accept_mcast(accept_mcast),
    .drop_pulse(nr_drop), .dbg_state(nr_state)
`ifdef ETH_RX_ADDR_FILTER_STATS_EN
    , .stat_accepted(nr_st_acc), .stat_dropped(nr_st_drop), .stat_runt(nr_st_runt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output ready: always 1, or ~30% duty when backpressure is enabled.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      m_tready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Main scoreboard, stall-hold check and event counters.
  bit         prev_stall = 1'b0;
  logic [9:0] prev_beat  = '0;
  always @(negedge clock) begin
    if (prev_stall && rst_n)
      check("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, prev_beat});
    prev_stall = rst_n && m_tvalid && !m_tready;
    prev_beat  = {m_tlast, m_tuser, m_tdata};
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
      else check("out_beat", {m_tlast, m_tuser, m_tdata}, exp_q.pop_front());
    end
    if (drop_pulse) drop_cnt++;
    if (m_tvalid) vld_cnt++;
  end

  always @(negedge clock) begin
    if (rst_n && nr_m_tvalid) begin
      if (nr_q.size() == 0) check("nr_unexpected_beat", 1, 0);
      else check("nr_beat", {nr_m_tlast, nr_m_tuser, nr_m_tdata}, nr_q.pop_front());
    end
  end

  task automatic send_byte(input bit sel, input logic [7:0] d, input logic l, input logic u);
    int t = 0;
    s_tdata = d; s_tlast = l; s_tuser = u;
    if (sel) nr_tvalid = 1'b1; else s_tvalid = 1'b1;
    forever begin
      @(negedge clock);
      if (sel ? nr_tready : s_tready) break;
      stall_cnt++;
      t++;
      if (t > 2000) begin
        check("handshake_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock);
    #1;
    s_tvalid = 1'b0; nr_tvalid = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input logic [47:0] da, input int len,
                            input logic u, input bit fwd, input logic [7:0] seed);
    logic [7:0] b;
    logic       l, uu;
    for (int i = 0; i < len; i++) begin
      b  = (i < 6) ? da[47-8*i -: 8] : 8'(seed + 8'(i));
      l  = (i == len - 1);
      uu = l ? u : 1'b0;
      if (fwd) begin
        if (sel) nr_q.push_back({l, uu, b});
        else exp_q.push_back({l, uu, b});
      end
      send_byte(sel, b, l, uu);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || nr_q.size() != 0) && t < 5000) begin
      @(posedge clock);
      t++;
    end
    check("drain_left", exp_q.size() + nr_q.size(), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic frame_test(input string tag, input bit sel, input logic [47:0] da,
                            input int len, input logic u, input bit fwd,
                            input int exp_drops, input logic [7:0] seed);
    int d0 = drop_cnt, v0 = vld_cnt, s0 = stall_cnt;
    send_frame(sel, da, len, u, fwd, seed);
    drain();
    check({tag, "_drops"}, drop_cnt - d0, exp_drops);
    if (!fwd && !sel) begin
      check({tag, "_no_valid"}, vld_cnt - v0, 0);
      check({tag, "_no_stall"}, stall_cnt - s0, 0);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [7:0] b;
    rst_n = 1'b0; s_tvalid = 1'b0; nr_tvalid = 1'b0;
    s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0;
    mac = MAC; promisc = 1'b0; accept_mcast = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast",  m_tlast, 0);
    check("rst_drop",     drop_pulse, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(negedge clock);
    check("idle_state",    dbg_state, HDR);
    check("idle_s_tready", s_tready, 1);
    @(posedge clock); #1;

    frame_test("ucast",    1'b0, MAC,   64, 1'b0, 1'b1, 0, 8'h10);
    frame_test("mismatch", 1'b0, OTHER, 64, 1'b0, 1'b0, 1, 8'h20);
    frame_test("bcast",    1'b0, ETH_BCAST_ADDR, 64, 1'b0, 1'b1, 0, 8'h30);
    frame_test("mcast_off", 1'b0, MCAST, 64, 1'b0, 1'b0, 1, 8'h40);
    accept_mcast = 1'b1;
    frame_test("mcast_on", 1'b0, MCAST, 64, 1'b0, 1'b1, 0, 8'h50);
    accept_mcast = 1'b0;
    promisc = 1'b1;
    frame_test("promisc",  1'b0, OTHER, 20, 1'b1, 1'b1, 0, 8'h60);
    promisc = 1'b0;

    frame_test("runt_drop", 1'b0, MAC, 4, 1'b1, 1'b0, 1, 8'h00);
    frame_test("runt_fwd",  1'b1, MAC, 4, 1'b1, 1'b1, 0, 8'h00);
    frame_test("exact6",    1'b0, MAC, 6, 1'b1, 1'b1, 0, 8'h00);
    frame_test("exact6_miss", 1'b0, OTHER, 6, 1'b0, 1'b0, 1, 8'h00);

    bp_en = 1'b1;
    d0 = drop_cnt;
    send_frame(1'b0, MAC, 100, 1'b0, 1'b1, 8'h70);
    send_frame(1'b0, MAC, 100, 1'b1, 1'b1, 8'h90);
    drain();
    bp_en = 1'b0;
    check("bp_drops", drop_cnt - d0, 0);
    @(posedge clock); #1;

    // Reset during PASS with byte 20 on the bus; the frame tail becomes a new header.
    for (int i = 0; i < 20; i++) begin
      b = (i < 6) ? MAC[47-8*i -: 8] : 8'(8'h30 + 8'(i));
      exp_q.push_back({2'b00, b});
      send_byte(1'b0, b, 1'b0, 1'b0);
    end
    check("pre_rst_state", dbg_state, PASS);
    s_tdata = 8'(8'h30 + 8'd20); s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
    rst_n = 1'b0;
    @(negedge clock);
    check("midrst_s_tready", s_tready, 0);
    check("midrst_m_tvalid", m_tvalid, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(negedge clock);
    check("postrst_state",    dbg_state, HDR);
    check("postrst_m_tvalid", m_tvalid, 0);
    check("postrst_m_tuser",  m_tuser, 0);
    check("postrst_drop",     drop_pulse, 0);
    check("postrst_left",     exp_q.size(), 0);
    @(posedge clock); #1;
    d0 = drop_cnt;
    for (int i = 20; i < 64; i++) begin
      send_byte(1'b0, 8'(8'h30 + 8'(i)), i == 63, 1'b0);
    end
    drain();
    check("tail_drops", drop_cnt - d0, 1);
    frame_test("clean", 1'b0, MAC, 64, 1'b0, 1'b1, 0, 8'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_rx_addr_filter.md
Name: eth_rx_addr_filter

Overview:
- Sits directly downstream of the MII MAC's RX_AXIS output, 8-bit AXI-Stream, on the same 25 MHz `clock`.
- Buffers the 6-byte destination MAC of each received frame and decides whether to forward or drop the frame.
- Accepted frames: unicast match to `mac_addr`, broadcast, multicast when enabled, or anything when promiscuous.
- Forwarded frames go to the DMA/host-side consumer unchanged; rejected frames are silently consumed.

Parameters:
- HDR_BYTES, 6, destination-address bytes buffered before the decision; fixed at 6, parameterised for the bench only.
- RUNT_DROP, 1, 1 = drop frames ending inside the header; 0 = forward them unfiltered.

Ports:
- clock  in  1  stream clock
- reset  in  1  synchronous, active-low reset
- s_axis_tdata  in  8  RX byte from MAC
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  bad-frame flag, meaningful with tlast
- m_axis_tdata  out  8  filtered byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last byte
- m_axis_tuser  out  1  bad-frame flag, passed through
- mac_addr  in  48  local MAC; byte 0 = mac_addr[47:40], first on wire
- promisc  in  1  accept all frames
- accept_mcast  in  1  accept group addresses (byte0 bit0 = 1)
- drop_pulse  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state = HDR, byte index = 0.
  - s_axis_tready = 0 during reset, then 1 in HDR.
  - m_axis_tvalid, m_axis_tlast, m_axis_tuser and drop_pulse are all 0.
  - An in-flight frame is abandoned; its remaining bytes are treated as a new frame's header.
- Config inputs (mac_addr, promisc, accept_mcast) are sampled at the decision cycle only.
- States:
  - HDR: s_axis_tready = 1, m_axis_tvalid = 0. Each accepted byte is stored in hdr[idx] along with its tlast/tuser, and idx increments.
    - tlast before idx reaches 5 (runt): with RUNT_DROP = 1, pulse drop_pulse and stay in HDR with idx = 0. With RUNT_DROP = 0, go to EMIT with count = idx+1.
    - Byte idx 5 accepted: evaluate match. match = promisc OR hdr == mac_addr OR hdr == 48'hFFFFFFFFFFFF OR (accept_mcast AND hdr[0][0]).
      - match: go to EMIT, count = 6.
      - no match and the byte carried tlast: pulse drop_pulse, go to HDR.
      - no match otherwise: go to DROP.
  - EMIT: s_axis_tready = 0. Presents hdr[0..count-1] registered on m_axis_*, advancing on m_axis_tready.
    - m_axis_tlast/m_axis_tuser are asserted only on a stored byte that carried tlast.
    - After the last stored byte: go to HDR if it carried tlast, else go to PASS.
  - PASS: combinational pass-through.
    - m_axis_tdata/tvalid/tlast/tuser = s_axis_*, and s_axis_tready = m_axis_tready.
    - On a tlast handshake: go to HDR with idx = 0.
  - DROP: s_axis_tready = 1, m_axis_tvalid = 0. On tlast accepted: pulse drop_pulse, go to HDR.
- Latency: the first output byte appears 1 cycle after the 6th header byte is accepted; after that, 1 byte/cycle with no bubbles when m_axis_tready = 1.
- m_axis_tvalid never drops without a handshake. m_axis_tdata is stable while tvalid && !tready.
- tuser is never interpreted, only forwarded; bad frames are filtered by address like good ones.
- Back-to-back frames: HDR accepts the next frame's byte 0 in the cycle after the previous tlast handshake.

Optional Feature:
- Macro ETH_RX_ADDR_FILTER_STATS_EN.
- Defined: adds outputs `stat_accepted[31:0]`, `stat_dropped[31:0]` and `stat_runt[15:0]`.
  - Counters increment at, respectively, the decision-to-EMIT, the drop_pulse, and the runt detection.
  - Counters saturate at all-ones and clear on reset.
- Undefined: no counter ports or logic; drop_pulse is still present.

Decomposition:
- Shared package eth_pkg:
  - ETH_ADDR_BYTES = 6 and ETH_BCAST_ADDR = 48'hFFFFFFFFFFFF.
  - Filter state enum {HDR, EMIT, PASS, DROP}.
- One sub-module, eth_addr_match: a combinational compare of the 6-byte header against mac_addr, broadcast and multicast, returning match. It is reusable by a future TX loopback filter.

Test Plan:
- Unicast match: mac_addr = 02:00:00:00:00:01, 64-byte frame to that DA, m_axis_tready = 1 → all 64 bytes out in order, tlast on byte 64, drop_pulse never asserted.
- Mismatch: DA = 02:00:00:00:00:02, promisc = 0, 64 bytes → no m_axis_tvalid, s_axis_tready = 1 throughout, one drop_pulse on byte 64.
- Broadcast and multicast: DA = FF:FF:FF:FF:FF:FF → forwarded. DA = 01:00:5E:00:00:01 → dropped with accept_mcast = 0, forwarded with accept_mcast = 1.
- Runt: a 4-byte frame with tlast on byte 4 → RUNT_DROP = 1 gives one drop_pulse and no output; RUNT_DROP = 0 gives 4 bytes out with tlast/tuser preserved. A 6-byte exact frame is forwarded with tlast on byte 6.
- Backpressure: random m_axis_tready at 30% duty with two back-to-back matching 100-byte frames (second with tuser = 1) → byte-exact output, tuser = 1 only on the second frame's last byte, output stable while stalled.
- Reset mid-frame: reset = 0 for 1 cycle during PASS at byte 20 → outputs go to 0 next cycle. The following 6 input bytes are treated as a fresh header, so a subsequent clean frame is filtered correctly.
